i2cmb_wb_cmd_sequencer: RTL and testbench

//  Hardware Wishbone master that sits directly upstream of the iicmb_m_wb controller.

---
 rtl/i2cmb_wb_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i2cmb_wb_cmd_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2cmb_wb_cmd_sequencer.sv
// Wishbone master that drives an iicmb_m_wb controller: turns single-byte I2C
// requests into CSR/DPR/CMDR register sequences and returns a status/data response.
module i2cmb_wb_cmd_sequencer #(
  parameter logic [7:0]  BUS_ID      = 8'h00,
  parameter int unsigned IRQ_TIMEOUT = 65535,
  parameter int unsigned WB_ADDR_W   = 2,
  parameter int unsigned WB_DATA_W   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_rw_i,
  input  logic [6:0]           req_addr_i,
  input  logic [7:0]           req_data_i,
  output logic                 rsp_valid_o,
  output logic [2:0]           rsp_status_o,
  output logic [7:0]           rsp_data_o,
  output logic                 cyc_o,
  output logic                 stb_o,
  output logic                 we_o,
  output logic [WB_ADDR_W-1:0] adr_o,
  output logic [WB_DATA_W-1:0] dat_o,
  input  logic [WB_DATA_W-1:0] dat_i,
  input  logic                 ack_i,
  input  logic                 irq_i
);

  localparam logic [WB_ADDR_W-1:0] ADR_CSR  = WB_ADDR_W'(0);
  localparam logic [WB_ADDR_W-1:0] ADR_DPR  = WB_ADDR_W'(1);
  localparam logic [WB_ADDR_W-1:0] ADR_CMDR = WB_ADDR_W'(2);

  localparam logic [7:0] CSR_ENABLE   = 8'hC0;
  localparam logic [7:0] CMD_WRITE    = 8'h01;
  localparam logic [7:0] CMD_READ_NAK = 8'h03;
  localparam logic [7:0] CMD_START    = 8'h04;
  localparam logic [7:0] CMD_STOP     = 8'h05;
  localparam logic [7:0] CMD_SET_BUS  = 8'h06;

  localparam logic [2:0] RSP_OK      = 3'd0;
  localparam logic [2:0] RSP_NAK     = 3'd1;
  localparam logic [2:0] RSP_AL      = 3'd2;
  localparam logic [2:0] RSP_ERR     = 3'd3;
  localparam logic [2:0] RSP_TIMEOUT = 3'd4;

  localparam int unsigned    CNT_W    = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(IRQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_ISSUE,
    S_ACCESS,
    S_WAIT_IRQ,
    S_IDLE
  } state_t;

  // Each phase names one register access; chk_q turns a command phase into
  // the CMDR read-back that follows its irq.
  typedef enum logic [3:0] {
    PH_CSR,
    PH_BUS_DPR,
    PH_SET_BUS,
    PH_START,
    PH_ADDR_DPR,
    PH_ADDR_CMD,
    PH_DATA_DPR,
    PH_DATA_CMD,
    PH_READ_CMD,
    PH_READ_DPR,
    PH_STOP
  } phase_t;

  function automatic phase_t next_phase(phase_t p, logic rw);
    case (p)
      PH_CSR:      next_phase = PH_BUS_DPR;
      PH_BUS_DPR:  next_phase = PH_SET_BUS;
      PH_START:    next_phase = PH_ADDR_DPR;
      PH_ADDR_DPR: next_phase = PH_ADDR_CMD;
      PH_ADDR_CMD: next_phase = rw ? PH_READ_CMD : PH_DATA_DPR;
      PH_DATA_DPR: next_phase = PH_DATA_CMD;
      PH_DATA_CMD: next_phase = PH_STOP;
      PH_READ_CMD: next_phase = PH_READ_DPR;
      PH_READ_DPR: next_phase = PH_STOP;
      default:     next_phase = PH_CSR;
    endcase
  endfunction

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  state_t          state_q;
  phase_t          phase_q;
  logic            chk_q;
  logic            req_rw_q;
  logic [6:0]      req_addr_q;
  logic [7:0]      req_data_q;
  logic [2:0]      pend_status_q;
  logic [7:0]      rd_data_q;
  logic [CNT_W-1:0] tmo_cnt_q;

  logic                 acc_we;
  logic [WB_ADDR_W-1:0] acc_adr;
  logic [WB_DATA_W-1:0] acc_dat;
  logic                 acc_is_cmd;
  logic [2:0]           cmd_status;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    acc_we  = 1'b1;
    acc_adr = ADR_CMDR;
    acc_dat = '0;
    if (chk_q) begin
      acc_we = 1'b0;
    end else begin
      case (phase_q)
        PH_CSR:      begin acc_adr = ADR_CSR; acc_dat = WB_DATA_W'(CSR_ENABLE); end
        PH_BUS_DPR:  begin acc_adr = ADR_DPR; acc_dat = WB_DATA_W'(BUS_ID); end
        PH_SET_BUS:  acc_dat = WB_DATA_W'(CMD_SET_BUS);
        PH_START:    acc_dat = WB_DATA_W'(CMD_START);
        PH_ADDR_DPR: begin acc_adr = ADR_DPR; acc_dat = WB_DATA_W'({req_addr_q, req_rw_q}); end
        PH_ADDR_CMD: acc_dat = WB_DATA_W'(CMD_WRITE);
        PH_DATA_DPR: begin acc_adr = ADR_DPR; acc_dat = WB_DATA_W'(req_data_q); end
        PH_DATA_CMD: acc_dat = WB_DATA_W'(CMD_WRITE);
        PH_READ_CMD: acc_dat = WB_DATA_W'(CMD_READ_NAK);
        PH_READ_DPR: begin acc_we = 1'b0; acc_adr = ADR_DPR; end
        PH_STOP:     acc_dat = WB_DATA_W'(CMD_STOP);
        default:     ;
      endcase
    end
  end

  assign acc_is_cmd = !chk_q && acc_we && (acc_adr == ADR_CMDR);

  // CMDR response bits: DON=7, NAK=6, AL=5, ERR=4; a read with none set is an error.
  always_comb begin
    if      (dat_i[4]) cmd_status = RSP_ERR;
    else if (dat_i[5]) cmd_status = RSP_AL;
    else if (dat_i[6]) cmd_status = RSP_NAK;
    else if (dat_i[7]) cmd_status = RSP_OK;
    else               cmd_status = RSP_ERR;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_ISSUE;
      phase_q       <= PH_CSR;
      chk_q         <= 1'b0;
      req_rw_q      <= 1'b0;
      req_addr_q    <= '0;
      req_data_q    <= '0;
      pend_status_q <= RSP_OK;
      rd_data_q     <= '0;
      tmo_cnt_q     <= '0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      req_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_status_o  <= '0;
      rsp_data_o    <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            req_rw_q      <= req_rw_i;
            req_addr_q    <= req_addr_i;
            req_data_q    <= req_data_i;
            pend_status_q <= RSP_OK;
            rd_data_q     <= '0;
            req_ready_o   <= 1'b0;
            phase_q       <= PH_START;
            chk_q         <= 1'b0;
            state_q       <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cyc_o   <= 1'b1;
          stb_o   <= 1'b1;
          we_o    <= acc_we;
          adr_o   <= acc_adr;
          dat_o   <= acc_dat;
          state_q <= S_ACCESS;
        end

        S_ACCESS: begin
          if (ack_i) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
            if (chk_q) begin
              chk_q <= 1'b0;
              if (phase_q == PH_SET_BUS) begin
                if (cmd_status == RSP_ERR) begin
                  phase_q <= PH_CSR;
                  state_q <= S_ISSUE;
                end else begin
                  req_ready_o <= 1'b1;
                  state_q     <= S_IDLE;
                end
              end else if (cmd_status == RSP_ERR || cmd_status == RSP_AL) begin
                // Arbitration loss or error leaves the bus alone: no Stop.
                rsp_valid_o  <= 1'b1;
                rsp_status_o <= cmd_status;
                rsp_data_o   <= '0;
                req_ready_o  <= 1'b1;
                state_q      <= S_IDLE;
              end else if (phase_q == PH_STOP) begin
                rsp_valid_o  <= 1'b1;
                rsp_status_o <= pend_status_q;
                rsp_data_o   <= (pend_status_q == RSP_OK) ? rd_data_q : 8'h00;
                req_ready_o  <= 1'b1;
                state_q      <= S_IDLE;
              end else if (cmd_status == RSP_NAK) begin
                pend_status_q <= RSP_NAK;
                phase_q       <= PH_STOP;
                state_q       <= S_ISSUE;
              end else begin
                phase_q <= next_phase(phase_q, req_rw_q);
                state_q <= S_ISSUE;
              end
            end else if (acc_is_cmd) begin
              tmo_cnt_q <= CNT_LOAD;
              state_q   <= S_WAIT_IRQ;
            end else begin
              if (phase_q == PH_READ_DPR) rd_data_q <= dat_i[7:0];
              phase_q <= next_phase(phase_q, req_rw_q);
              state_q <= S_ISSUE;
            end
          end
        end

        S_WAIT_IRQ: begin
          if (irq_i) begin
            chk_q   <= 1'b1;
            state_q <= S_ISSUE;
          end else if (tmo_cnt_q == '0) begin
            // A lost controller is re-initialised; INIT itself never responds.
            if (phase_q != PH_SET_BUS) begin
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= RSP_TIMEOUT;
              rsp_data_o   <= '0;
            end
            phase_q <= PH_CSR;
            state_q <= S_ISSUE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q - 1'b1;
          end
        end

        default: state_q <= S_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2cmb_wb_cmd_sequencer.sv
// Bench for i2cmb_wb_cmd_sequencer: behavioural iicmb controller plus I2C slave,
// with scoreboards for the Wishbone access stream and the response stream.
module tb_i2cmb_wb_cmd_sequencer;

  localparam logic [7:0] BUS_ID = 8'h03;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  logic       rsp_valid;
  logic [2:0] rsp_status;
  logic [7:0] rsp_data;
  logic       cyc, stb, we;
  logic [1:0] adr;
  logic [7:0] dat_o;
  logic [7:0] dat_i = '0;
  logic       ack = 1'b0;
  logic       irq = 1'b0;

  i2cmb_wb_cmd_sequencer #(
    .BUS_ID(BUS_ID), .IRQ_TIMEOUT(100), .WB_ADDR_W(2), .WB_DATA_W(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_data_i(req_data),
    .rsp_valid_o(rsp_valid), .rsp_status_o(rsp_status), .rsp_data_o(rsp_data),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
    .dat_i(dat_i), .ack_i(ack), .irq_i(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [1:0] adr; logic [7:0] dat; } wb_t;
  typedef struct { logic [2:0] st; logic [7:0] data; } rsp_t;

  wb_t  exp_wb[$];
  rsp_t exp_rsp[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_cnt = 0;
  int   rsp_cyc = 0;
  int   accept_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
    wb_t e; e.we = 1'b1; e.adr = a; e.dat = d; exp_wb.push_back(e);
  endtask
  task automatic exp_r(input logic [1:0] a);
    wb_t e; e.we = 1'b0; e.adr = a; e.dat = 8'h00; exp_wb.push_back(e);
  endtask
  task automatic exp_cmd(input logic [7:0] c);
    exp_w(2'd2, c); exp_r(2'd2);
  endtask
  task automatic exp_init();
    exp_w(2'd0, 8'hC0); exp_w(2'd1, BUS_ID); exp_cmd(8'h06);
  endtask
  task automatic exp_resp(input logic [2:0] st, input logic [7:0] d);
    rsp_t r; r.st = st; r.data = d; exp_rsp.push_back(r);
  endtask

  // Behavioural iicmb controller with one I2C slave at 0x22 returning 0xA5.
  logic       ack_en = 1'b1;
  logic [7:0] dpr = '0;
  logic [7:0] cmd_res = '0;
  int         irq_cnt = 0;
  logic       addr_phase = 1'b0;
  logic [6:0] cur_addr = '0;
  logic [6:0] last_wr_addr = '0;
  logic [7:0] last_wr_data = '0;
  logic [7:0] inj_status = '0;
  logic       drop_irq = 1'b0;

  task automatic model_cmd(input logic [7:0] c);
    logic [7:0] res;
    res = 8'h80;
    case (c)
      8'h04: addr_phase = 1'b1;
      8'h01: begin
        if (addr_phase) begin
          addr_phase = 1'b0;
          cur_addr = dpr[7:1];
          if (cur_addr != 7'h22) res = 8'h40;
        end else begin
          last_wr_addr = cur_addr;
          last_wr_data = dpr;
        end
        if (inj_status != 8'h00) begin res = inj_status; inj_status = 8'h00; end
      end
      8'h03: dpr = 8'hA5;
      8'h05: addr_phase = 1'b0;
      default: ;
    endcase
    cmd_res = res;
    if (drop_irq) drop_irq = 1'b0;
    else          irq_cnt = 3;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        ack = 1'b0; irq = 1'b0; irq_cnt = 0; dat_i = '0;
      end else begin
        if (irq_cnt > 0) begin
          irq_cnt--;
          if (irq_cnt == 0) irq = 1'b1;
        end
        if (ack) begin
          ack = 1'b0;
        end else if (cyc && stb && ack_en) begin
          ack = 1'b1;
          if (we) begin
            if (adr == 2'd1) dpr = dat_o;
            else if (adr == 2'd2) model_cmd(dat_o);
          end else begin
            if (adr == 2'd1) dat_i = dpr;
            else if (adr == 2'd2) begin dat_i = cmd_res; irq = 1'b0; end
            else dat_i = 8'h00;
          end
        end
      end
    end
  end

  initial forever begin @(posedge clk); cyc_cnt++; end

  // Wishbone monitor: each rising cyc_o is one access, checked against the queue.
  logic prev_cyc = 1'b0;
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (cyc && !prev_cyc) begin
        if (exp_wb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL wb_unexpected: got we=%0b adr=%0d dat=0x%0h, want no access", we, adr, dat_o);
        end else begin
          e = exp_wb.pop_front();
          check("wb_stb", 32'(stb), 32'd1);
          check("wb_we", 32'(we), 32'(e.we));
          check("wb_adr", 32'(adr), 32'(e.adr));
          if (e.we) check("wb_dat", 32'(dat_o), 32'(e.dat));
        end
      end
      prev_cyc = cyc;
    end
  end

  // Response monitor.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_cyc = cyc_cnt;
        if (exp_rsp.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL rsp_unexpected: got status=%0d data=0x%0h, want none", rsp_status, rsp_data);
        end else begin
          r = exp_rsp.pop_front();
          check("rsp_status", 32'(rsp_status), 32'(r.st));
          check("rsp_data", 32'(rsp_data), 32'(r.data));
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_wb.size() == 0 && exp_rsp.size() == 0 && req_ready) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    accept_cyc = cyc_cnt;
    req_valid = 1'b0;
  endtask

  initial begin
    int lat;
    logic done;
    // T1: reset values, then INIT
    #2;
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp", 32'({rsp_valid, rsp_status, rsp_data, we, adr, dat_o}), 32'd0);
    exp_init();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    wait_idle("t1_init_done", 300);
    check("t1_ready", 32'(req_ready), 32'd1);

    // T2: write 0x5A to 0x22
    exp_cmd(8'h04); exp_w(2'd1, 8'h44); exp_cmd(8'h01);
    exp_w(2'd1, 8'h5A); exp_cmd(8'h01); exp_cmd(8'h05);
    exp_resp(3'd0, 8'h00);
    send(1'b0, 7'h22, 8'h5A);
    wait_idle("t2_done", 400);
    check("t2_slave_addr", 32'(last_wr_addr), 32'h22);
    check("t2_slave_data", 32'(last_wr_data), 32'h5A);

    // T3: read from 0x22
    exp_cmd(8'h04); exp_w(2'd1, 8'h45); exp_cmd(8'h01);
    exp_cmd(8'h03); exp_r(2'd1); exp_cmd(8'h05);
    exp_resp(3'd0, 8'hA5);
    send(1'b1, 7'h22, 8'h00);
    wait_idle("t3_done", 400);

    // T4: absent slave, write then read
    exp_cmd(8'h04); exp_w(2'd1, 8'h22); exp_cmd(8'h01); exp_cmd(8'h05);
    exp_resp(3'd1, 8'h00);
    send(1'b0, 7'h11, 8'h33);
    wait_idle("t4w_done", 400);
    exp_cmd(8'h04); exp_w(2'd1, 8'h23); exp_cmd(8'h01); exp_cmd(8'h05);
    exp_resp(3'd1, 8'h00);
    send(1'b1, 7'h11, 8'h00);
    wait_idle("t4r_done", 400);

    // Arbitration loss (AL beats NAK) and error (ERR beats all): no Stop
    inj_status = 8'h60;
    exp_cmd(8'h04); exp_w(2'd1, 8'h44); exp_cmd(8'h01);
    exp_resp(3'd2, 8'h00);
    send(1'b0, 7'h22, 8'h77);
    wait_idle("al_done", 400);
    inj_status = 8'h70;
    exp_cmd(8'h04); exp_w(2'd1, 8'h45); exp_cmd(8'h01);
    exp_resp(3'd3, 8'h00);
    send(1'b1, 7'h22, 8'h00);
    wait_idle("err_done", 400);

    // T5: irq never arrives for Start -> TIMEOUT, then INIT reissued
    drop_irq = 1'b1;
    exp_w(2'd2, 8'h04);
    exp_init();
    exp_resp(3'd4, 8'h00);
    send(1'b0, 7'h22, 8'h12);
    wait_idle("t5_done", 600);
    lat = rsp_cyc - accept_cyc;
    check("t5_timeout_latency", 32'(lat >= 100 && lat <= 105), 32'd1);

    // T6: reset while an access waits for ack
    ack_en = 1'b0;
    exp_w(2'd2, 8'h04);
    send(1'b0, 7'h22, 8'h11);
    for (int i = 0; i < 20 && !cyc; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("t6_cyc_held", 32'(cyc), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    check("t6_cyc_drop", 32'(cyc), 32'd0);
    check("t6_stb_drop", 32'(stb), 32'd0);
    check("t6_ready_low", 32'(req_ready), 32'd0);
    exp_init();
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (req_ready) done = 1'b1;
    end
    check("t6_ready_returns", 32'(done), 32'd1);
    check("t6_init_before_ready", 32'(exp_wb.size()), 32'd0);

    // Normal traffic after the reset
    exp_cmd(8'h04); exp_w(2'd1, 8'h44); exp_cmd(8'h01);
    exp_w(2'd1, 8'hC3); exp_cmd(8'h01); exp_cmd(8'h05);
    exp_resp(3'd0, 8'h00);
    send(1'b0, 7'h22, 8'hC3);
    wait_idle("t7_done", 400);
    check("t7_slave_data", 32'(last_wr_data), 32'hC3);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

endmodule
